nsc_push_arbiter: RTL and testbench

- Round-robin burst arbiter that shares one 18-bit-write, 9-bit-read, 64-entry dual-clock FIFO among NUM_REQ write requesters inside the NAND storage controller.
- A requester owns the FIFO push port for a whole burst, from grant until its beat flagged last is accepted.
- A new burst is granted only when the FIFO reports enough free space. Beats pass combinationally to the FIFO push port.

---
 rtl/nsc_push_arbiter_if.sv | 27 ++
 rtl/nsc_push_arbiter.sv | 123 ++++++++++++
 tb/tb_nsc_push_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/nsc_push_arbiter_if.sv
// Push-port bundle between NUM_REQ burst writers, the arbiter and the shared
// 18-bit-write FIFO. The arbiter connects through the slave modport.
interface nsc_push_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    iReqValid;
  logic [18*NUM_REQ-1:0] iReqData;
  logic [NUM_REQ-1:0]    iReqLast;
  logic [NUM_REQ-1:0]    oReqReady;
  logic [NUM_REQ-1:0]    oGrant;
  logic [17:0]           oPushData;
  logic                  oPushEnable;
  logic                  iIsFull;
  logic [5:0]            iDataCount;
  logic [7:0]            oBeatCount;
  logic                  oBusy;

  modport slave (
    input  iReqValid, iReqData, iReqLast, iIsFull, iDataCount,
    output oReqReady, oGrant, oPushData, oPushEnable, oBeatCount, oBusy
  );

  modport master (
    output iReqValid, iReqData, iReqLast, iIsFull, iDataCount,
    input  oReqReady, oGrant, oPushData, oPushEnable, oBeatCount, oBusy
  );
endinterface

// File: rtl/nsc_push_arbiter.sv
// Round-robin burst arbiter for the shared NAND-controller write FIFO: one
// requester owns the push port from grant until its last beat is accepted.
module nsc_push_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MIN_SPACE = 8
) (
  input logic                iClock,
  input logic                iReset,
  nsc_push_arbiter_if.slave  bus
);

  localparam int IdxW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} stateT;

  stateT             state, stateNext;
  logic [NUM_REQ-1:0] grantReg;
  logic [IdxW-1:0]    ownerIdx;
  logic [IdxW-1:0]    lastOwner;
  logic [7:0]         beatCount;

  logic [IdxW-1:0]    winnerIdx;
  logic               winnerFound;
  int                 cand;
  logic [6:0]         freeSpace;
  logic               spaceOk;
  logic               ownerValid;
  logic               ownerLast;
  logic [17:0]        ownerData;
  logic               startBurst;
  logic               pushEnable;
  logic [17:0]        pushData;
  logic [NUM_REQ-1:0] reqReady;

  // Free entries need 7 bits so an empty FIFO reports 64.
  assign freeSpace = 7'd64 - {1'b0, bus.iDataCount};
  assign spaceOk   = freeSpace >= 7'(MIN_SPACE);

  // Rotating search starting just after the previous owner.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    winnerIdx   = lastOwner;
    winnerFound = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(lastOwner) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!winnerFound && bus.iReqValid[cand]) begin
        winnerFound = 1'b1;
        winnerIdx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    ownerValid = 1'b0;
    ownerLast  = 1'b0;
    ownerData  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ownerIdx == IdxW'(k)) begin
        ownerValid = bus.iReqValid[k];
        ownerLast  = bus.iReqLast[k];
        ownerData  = bus.iReqData[k*18 +: 18];
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    startBurst = 1'b0;
    reqReady   = '0;
    pushEnable = 1'b0;
    pushData   = '0;
    case (state)
      IDLE: begin
        if (winnerFound && !bus.iIsFull && spaceOk) begin
          stateNext  = GRANT;
          startBurst = 1'b1;
        end
      end
      GRANT: begin
        reqReady   = bus.iIsFull ? '0 : grantReg;
        pushEnable = ownerValid & ~bus.iIsFull;
        if (pushEnable) pushData = ownerData;
        if (pushEnable && ownerLast) stateNext = IDLE;
      end
    endcase
  end

  // The pointer resets to the top requester so requester 0 wins first.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      grantReg  <= '0;
      ownerIdx  <= '0;
      lastOwner <= IdxW'(NUM_REQ - 1);
      beatCount <= '0;
    end else if (startBurst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      grantReg  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winnerIdx;
      ownerIdx  <= winnerIdx;
      beatCount <= '0;
    end else if (pushEnable) begin
      if (beatCount != 8'hFF) beatCount <= beatCount + 8'd1;
      if (ownerLast) begin
        grantReg  <= '0;
        lastOwner <= ownerIdx;
      end
    end
  end

  assign bus.oReqReady   = reqReady;
  assign bus.oGrant      = grantReg;
  assign bus.oPushData   = pushData;
  assign bus.oPushEnable = pushEnable;
  assign bus.oBeatCount  = beatCount;
  assign bus.oBusy       = (state == GRANT);

endmodule

// File: tb/tb_nsc_push_arbiter.sv
// Directed bench for nsc_push_arbiter: latency, round-robin order, space gate,
// full stalls, async reset and beat-count saturation.
module tb_nsc_push_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nsc_push_arbiter_if #(.NUM_REQ(2)) bus ();

  nsc_push_arbiter #(.NUM_REQ(2), .MIN_SPACE(8)) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [17:0] pushed[$];

  // FIFO-side capture of every accepted beat.
  always @(posedge clk) if (bus.oPushEnable) pushed.push_back(bus.oPushData);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int k, input logic v, input logic [17:0] d, input logic l);
    bus.iReqValid[k]         = v;
    bus.iReqData[k*18 +: 18] = d;
    bus.iReqLast[k]          = l;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_grant"}, bus.oGrant, 0);
    check({tag, "_ready"}, bus.oReqReady, 0);
    check({tag, "_pushen"}, bus.oPushEnable, 0);
    check({tag, "_pushdata"}, bus.oPushData, 0);
    check({tag, "_beats"}, bus.oBeatCount, 0);
    check({tag, "_busy"}, bus.oBusy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0]  expG [8];
  logic [17:0] expD [8];
  int          sent, cyc, bad;
  logic        acc, hit100;

  initial begin
    rst            = 1'b1;
    bus.iReqValid  = '0;
    bus.iReqData   = '0;
    bus.iReqLast   = '0;
    bus.iIsFull    = 1'b0;
    bus.iDataCount = '0;
    repeat (2) @(negedge clk);
    #1 checkIdleOutputs("reset");
    rst = 1'b0;

    // Single 3-beat burst from requester 0, empty FIFO.
    pushed.delete();
    @(negedge clk); setReq(0, 1, 18'h1, 0);
    #1 check("t1_latency_grant", bus.oGrant, 0);
    @(negedge clk);
    #1 check("t1_grant", bus.oGrant, 2'b01);
    check("t1_busy", bus.oBusy, 1);
    check("t1_ready", bus.oReqReady, 2'b01);
    check("t1_beat1_en", bus.oPushEnable, 1);
    @(negedge clk); setReq(0, 1, 18'h2, 0);
    #1 check("t1_beat2_en", bus.oPushEnable, 1);
    @(negedge clk); setReq(0, 1, 18'h3, 1);
    #1 check("t1_beat3_en", bus.oPushEnable, 1);
    @(negedge clk); setReq(0, 0, 18'h0, 0);
    #1 check("t1_idle_grant", bus.oGrant, 0);
    check("t1_idle_busy", bus.oBusy, 0);
    check("t1_beats", bus.oBeatCount, 3);
    check("t1_fifo_size", pushed.size(), 3);
    if (pushed.size() == 3) begin
      check("t1_fifo0", pushed[0], 18'h1);
      check("t1_fifo1", pushed[1], 18'h2);
      check("t1_fifo2", pushed[2], 18'h3);
    end

    // Round robin with both requesters issuing 1-beat bursts after a reset.
    expG = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    expD = '{18'h0, 18'h100, 18'h0, 18'h200, 18'h0, 18'h100, 18'h0, 18'h200};
    @(negedge clk); rst = 1'b1;
    #1 rst = 1'b0;
    setReq(0, 1, 18'h100, 1);
    setReq(1, 1, 18'h200, 1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1 check($sformatf("t2_grant_c%0d", c), bus.oGrant, expG[c]);
      check($sformatf("t2_data_c%0d", c), bus.oPushData, expD[c]);
    end

    // Space gate: 7 free entries blocks the grant, 8 allows it.
    @(negedge clk);
    setReq(1, 0, 18'h0, 0);
    setReq(0, 1, 18'hAA, 1);
    bus.iDataCount = 6'd57;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1 check($sformatf("t3_nospace_c%0d", c), bus.oGrant, 0);
    end
    @(negedge clk); bus.iDataCount = 6'd56;
    #1 check("t3_before_edge", bus.oGrant, 0);
    @(negedge clk); bus.iDataCount = 6'd0;
    #1 check("t3_grant", bus.oGrant, 2'b01);
    check("t3_data", bus.oPushData, 18'hAA);

    // Full stall mid-burst by requester 1 while requester 0 keeps waiting.
    @(negedge clk);
    pushed.delete();
    setReq(0, 1, 18'hBB, 1);
    setReq(1, 1, 18'h11, 0);
    #1 check("t4_idle", bus.oGrant, 0);
    @(negedge clk);
    #1 check("t4_grant", bus.oGrant, 2'b10);
    check("t4_ready", bus.oReqReady, 2'b10);
    @(negedge clk); setReq(1, 1, 18'h12, 0);
    #1 check("t4_beat2_en", bus.oPushEnable, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); setReq(1, 1, 18'h13, 0); bus.iIsFull = 1'b1;
      #1 check($sformatf("t4_full_ready_c%0d", c), bus.oReqReady, 0);
      check($sformatf("t4_full_en_c%0d", c), bus.oPushEnable, 0);
      check($sformatf("t4_full_grant_c%0d", c), bus.oGrant, 2'b10);
    end
    @(negedge clk); bus.iIsFull = 1'b0;
    #1 check("t4_resume_data", bus.oPushData, 18'h13);
    @(negedge clk); setReq(1, 1, 18'h14, 1);
    #1 check("t4_last_en", bus.oPushEnable, 1);
    @(negedge clk); setReq(1, 0, 18'h0, 0);
    #1 check("t4_idle_after", bus.oGrant, 0);
    check("t4_beats", bus.oBeatCount, 4);
    @(negedge clk);
    #1 check("t4_waiter_grant", bus.oGrant, 2'b01);
    check("t4_waiter_data", bus.oPushData, 18'hBB);
    @(negedge clk);
    check("t4_fifo_size", pushed.size(), 5);
    if (pushed.size() == 5) begin
      check("t4_fifo0", pushed[0], 18'h11);
      check("t4_fifo1", pushed[1], 18'h12);
      check("t4_fifo2", pushed[2], 18'h13);
      check("t4_fifo3", pushed[3], 18'h14);
      check("t4_fifo4", pushed[4], 18'hBB);
    end

    // Async reset during beat 2 of a burst owned by requester 1.
    setReq(0, 0, 18'h0, 0);
    setReq(1, 1, 18'h21, 0);
    #1 check("t5_idle", bus.oGrant, 0);
    @(negedge clk);
    #1 check("t5_grant", bus.oGrant, 2'b10);
    @(negedge clk); setReq(1, 1, 18'h22, 0);
    #1 check("t5_beat2_en", bus.oPushEnable, 1);
    rst = 1'b1;
    #1 checkIdleOutputs("t5_reset");
    @(negedge clk);
    rst = 1'b0;
    setReq(0, 1, 18'h31, 1);
    setReq(1, 1, 18'h23, 0);
    #1 check("t5_after_idle", bus.oGrant, 0);
    @(negedge clk);
    #1 check("t5_req0_first", bus.oGrant, 2'b01);
    check("t5_req0_data", bus.oPushData, 18'h31);

    // 300-beat burst from requester 1 with periodic full stalls.
    @(negedge clk);
    setReq(0, 0, 18'h0, 0);
    pushed.delete();
    sent   = 0;
    cyc    = 0;
    hit100 = 1'b0;
    while (sent < 300 && cyc < 1000) begin
      setReq(1, 1, 18'(sent), sent == 299);
      bus.iIsFull = (cyc % 50 == 49);
      #1;
      if (sent == 100 && !hit100) begin
        check("t6_beats_100", bus.oBeatCount, 100);
        hit100 = 1'b1;
      end
      acc = bus.oPushEnable;
      @(posedge clk);
      if (acc) sent++;
      cyc++;
      @(negedge clk);
    end
    setReq(1, 0, 18'h0, 0);
    bus.iIsFull = 1'b0;
    #1 check("t6_sent", sent, 300);
    check("t6_beats_sat", bus.oBeatCount, 255);
    check("t6_idle", bus.oGrant, 0);
    check("t6_fifo_size", pushed.size(), 300);
    bad = 0;
    foreach (pushed[i]) if (pushed[i] !== 18'(i)) bad++;
    check("t6_fifo_order", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
